// File: rtl/aes256_round_ctrl_pkg.sv
// Shared widths and FSM encoding for the AES-256 round sequencer.
package aes256_round_ctrl_pkg;

    localparam int unsigned NUM_ROUNDS = 14;
    localparam int unsigned KEY_W      = 256;
    localparam int unsigned BLK_W      = 128;
    localparam int unsigned RND_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/aes256_round_ctrl.sv
// AES-256 encrypt sequencer: accepts key+block, steps keyExpansion and the external
// round datapath through rounds 0..14, then presents the ciphertext.
module aes256_round_ctrl
    import aes256_round_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    input  logic [BLK_W-1:0] in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_block,
    output logic             busy,
    output logic [KEY_W-1:0] ke_key_in,
    output logic             ke_enable_round,
    output logic [RND_W-1:0] ke_round_num,
    input  logic [BLK_W-1:0] rk_in,
    output logic [BLK_W-1:0] rd_state,
    output logic             rd_final,
    input  logic [BLK_W-1:0] rd_result
);

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);
    localparam logic [RND_W-1:0] FINAL_RND  = RND_W'(NUM_ROUNDS);

    ctrl_state_e      state_q, state_d;
    logic [RND_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q;
    logic [BLK_W-1:0] blk_q;
    logic             accept;

    logic in_ready_d, out_valid_d, busy_d, enable_d, final_d;

    assign ke_round_num = cnt_q;
    assign ke_key_in    = key_q;
    assign rd_state     = blk_q;
    assign out_block    = blk_q;

    // Next state, next counter, and next-cycle control outputs decoded from state_d
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        enable_d    = 1'b0;
        final_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                accept = in_valid & in_ready;
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = RND_W'(1);
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (cnt_q >= LAST_ROUND) begin
                    cnt_d   = FINAL_RND;
                    state_d = ST_FINAL;
                end else begin
                    cnt_d = cnt_q + RND_W'(1);
                end
            end
            ST_FINAL: begin
                cnt_d   = '0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                cnt_d = '0;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_ROUND) || (state_d == ST_FINAL);
        enable_d    = (state_d == ST_LOAD) || (state_d == ST_ROUND);
        final_d     = (state_d == ST_FINAL);
    end

    // FSM, counter and control output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            ke_enable_round <= 1'b0;
            rd_final        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            in_ready        <= in_ready_d;
            out_valid       <= out_valid_d;
            busy            <= busy_d;
            ke_enable_round <= enable_d;
            rd_final        <= final_d;
        end
    end

    // Key and cipher-state registers; round 0 is a bare AddRoundKey
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
            blk_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        key_q <= in_key;
                        blk_q <= in_block;
                    end
                end
                ST_LOAD:  blk_q <= blk_q ^ rk_in;
                ST_ROUND: blk_q <= rd_result;
                ST_FINAL: blk_q <= rd_result;
                default:  blk_q <= blk_q;
            endcase
        end
    end

endmodule
